// File: rtl/capture_sequencer.sv
// Output-capture run sequencer: align, settle, decimated FIFO capture, done.
// Optional level trigger before capture is enabled by CAPTURE_TRIGGER_EN.
module capture_sequencer #(
    parameter int DATA_W       = 16,
    parameter int LEN_W        = 16,
    parameter int DECIM_W      = 8,
    parameter int ALIGN_CYCLES = 4,
    parameter int PIPE_LAT     = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [LEN_W-1:0]         length,
    input  logic [DECIM_W-1:0]       decim,
    input  logic signed [DATA_W-1:0] sample_in,
`ifdef CAPTURE_TRIGGER_EN
    input  logic signed [DATA_W-1:0] trig_level,
`endif
    input  logic                     fifo_full,
    output logic                     fifo_wr_en,
    output logic [DATA_W-1:0]        fifo_din,
    output logic                     block_reset,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [LEN_W-1:0]         count
);

    localparam int PH_MAX = (ALIGN_CYCLES > PIPE_LAT) ? ALIGN_CYCLES : PIPE_LAT;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0] ALIGN_LAST  = PH_W'(ALIGN_CYCLES - 1);
    localparam logic [PH_W-1:0] SETTLE_LAST =
        PH_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_SETTLE,
        S_CAPTURE,
        S_FINISH
`ifdef CAPTURE_TRIGGER_EN
        , S_ARM
`endif
    } state_e;

`ifdef CAPTURE_TRIGGER_EN
    localparam state_e POST_SETTLE = S_ARM;
`else
    localparam state_e POST_SETTLE = S_CAPTURE;
`endif

    state_e             state;
    logic [PH_W-1:0]    ph_cnt;
    logic [DECIM_W-1:0] dcnt;
    logic [DECIM_W-1:0] dec_q;
    logic [LEN_W-1:0]   len_q;
`ifdef CAPTURE_TRIGGER_EN
    logic signed [DATA_W-1:0] prev_sample;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            ph_cnt      <= '0;
            dcnt        <= '0;
            dec_q       <= '0;
            len_q       <= '0;
            fifo_wr_en  <= 1'b0;
            fifo_din    <= '0;
            block_reset <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            count       <= '0;
`ifdef CAPTURE_TRIGGER_EN
            prev_sample <= '0;
`endif
        end else begin
            fifo_wr_en <= 1'b0;
            done       <= 1'b0;
`ifdef CAPTURE_TRIGGER_EN
            prev_sample <= sample_in;
`endif
            if (state != S_IDLE && abort) begin
                state       <= S_IDLE;
                block_reset <= 1'b0;
                busy        <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            len_q    <= length;
                            dec_q    <= decim;
                            count    <= '0;
                            overflow <= 1'b0;
                            ph_cnt   <= '0;
                            dcnt     <= '0;
                            busy     <= 1'b1;
                            if (length == '0) begin
                                state <= S_FINISH;
                            end else begin
                                state       <= S_ALIGN;
                                block_reset <= 1'b1;
                            end
                        end
                    end
                    S_ALIGN: begin
                        if (ph_cnt == ALIGN_LAST) begin
                            block_reset <= 1'b0;
                            ph_cnt      <= '0;
                            dcnt        <= '0;
                            if (PIPE_LAT == 0) state <= POST_SETTLE;
                            else               state <= S_SETTLE;
                        end else begin
                            ph_cnt <= ph_cnt + 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        if (ph_cnt == SETTLE_LAST) begin
                            ph_cnt <= '0;
                            dcnt   <= '0;
                            state  <= POST_SETTLE;
                        end else begin
                            ph_cnt <= ph_cnt + 1'b1;
                        end
                    end
`ifdef CAPTURE_TRIGGER_EN
                    S_ARM: begin
                        dcnt <= '0;
                        if (prev_sample < trig_level && trig_level <= sample_in)
                            state <= S_CAPTURE;
                    end
`endif
                    S_CAPTURE: begin
                        dcnt <= (dcnt == dec_q) ? '0 : dcnt + 1'b1;
                        // Slots are fixed in time; a full FIFO drops the sample
                        if (dcnt == '0) begin
                            if (count != len_q) count <= count + 1'b1;
                            if (!fifo_full) begin
                                fifo_wr_en <= 1'b1;
                                fifo_din   <= sample_in;
                            end else begin
                                overflow <= 1'b1;
                            end
                            if (count >= len_q - 1'b1) state <= S_FINISH;
                        end
                    end
                    S_FINISH: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        state       <= S_IDLE;
                        block_reset <= 1'b0;
                        busy        <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Scoreboard bench for capture_sequencer: write values/timing, decimation,
// overflow, abort, zero length, reset; trigger test when CAPTURE_TRIGGER_EN.
module tb_capture_sequencer;

    localparam int DATA_W = 16;
    localparam int LEN_W  = 16;
    localparam int DW     = 8;
    localparam int ALIGN  = 4;
    localparam int PLAT   = 8;
`ifdef CAPTURE_TRIGGER_EN
    localparam int FIRST  = ALIGN + PLAT + 2;
`else
    localparam int FIRST  = ALIGN + PLAT + 1;
`endif

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     start = 1'b0;
    logic                     abort = 1'b0;
    logic [LEN_W-1:0]         length = '0;
    logic [DW-1:0]            decim = '0;
    logic signed [DATA_W-1:0] sample_in = '0;
`ifdef CAPTURE_TRIGGER_EN
    logic signed [DATA_W-1:0] trig_level = '0;
`endif
    logic                     fifo_full = 1'b0;
    logic                     fifo_wr_en;
    logic [DATA_W-1:0]        fifo_din;
    logic                     block_reset;
    logic                     busy;
    logic                     done;
    logic                     overflow;
    logic [LEN_W-1:0]         count;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] sb[$];
    int wr_edges[$];
    int obs_br, obs_br_first, obs_done, obs_done_edge;
    logic obs_busy_abort;

    capture_sequencer #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .DECIM_W(DW),
        .ALIGN_CYCLES(ALIGN), .PIPE_LAT(PLAT)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .abort(abort),
        .length(length),
        .decim(decim),
        .sample_in(sample_in),
`ifdef CAPTURE_TRIGGER_EN
        .trig_level(trig_level),
`endif
        .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en),
        .fifo_din(fifo_din),
        .block_reset(block_reset),
        .busy(busy),
        .done(done),
        .overflow(overflow),
        .count(count)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every write must match the next expected sample.
    always @(negedge clk) begin
        if (reset_n && fifo_wr_en) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL fifo_write: unexpected write din=%0d, none expected",
                         fifo_din);
            end else begin
                logic [DATA_W-1:0] exp_v;
                exp_v = sb.pop_front();
                if (fifo_din !== exp_v) begin
                    errors++;
                    $display("FAIL fifo_data: got %0d expected %0d", fifo_din, exp_v);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        sample_in = sample_in + 1'b1;
    endtask

    function automatic bit is_slot(int e, int len, int dec);
        int d;
        d = e - FIRST;
        if (d < 0) return 1'b0;
        if (d % (dec + 1) != 0) return 1'b0;
        return (d / (dec + 1)) < len;
    endfunction

    // Drives one run and records observations; comparisons live in the tests.
    task automatic drive_run(input int len, input int dec, input int full_slot,
                             input int abort_edge, input int mid_start, input int n);
        int si;
        bit sl;
        logic [DATA_W-1:0] v;
        wr_edges.delete();
        obs_br = 0;
        obs_br_first = -1;
        obs_done = 0;
        obs_done_edge = -1;
        obs_busy_abort = 1'b1;
        si = 0;
        length = LEN_W'(len);
        decim = DW'(dec);
`ifdef CAPTURE_TRIGGER_EN
        trig_level = sample_in + 16'sd13;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        if (block_reset) begin
            obs_br++;
            obs_br_first = 0;
        end
        for (int e = 1; e <= n; e++) begin
            sl = is_slot(e, len, dec) && (abort_edge < 0 || e < abort_edge);
            fifo_full = sl && (si == full_slot);
            abort = (e == abort_edge);
            start = (e == mid_start);
            v = sample_in;
            tick();
            fifo_full = 1'b0;
            abort = 1'b0;
            start = 1'b0;
            if (sl) begin
                if (si != full_slot) sb.push_back(v);
                si++;
            end
            if (block_reset) begin
                obs_br++;
                if (obs_br_first < 0) obs_br_first = e;
            end
            if (done) begin
                obs_done++;
                obs_done_edge = e;
            end
            if (fifo_wr_en) wr_edges.push_back(e);
            if (e == abort_edge) obs_busy_abort = busy;
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({fifo_wr_en, block_reset, busy, done, overflow} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {fifo_wr_en, block_reset, busy, done, overflow});
        end
        checks++;
        if (count !== '0 || fifo_din !== '0) begin
            errors++;
            $display("FAIL reset_data: count=%0d din=%0d expected 0/0", count, fifo_din);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        drive_run(5, 0, -1, -1, -1, FIRST + 10);
        checks++;
        if (obs_br !== ALIGN || obs_br_first !== 0) begin
            errors++;
            $display("FAIL basic_block_reset: cycles=%0d first=%0d expected %0d/0",
                     obs_br, obs_br_first, ALIGN);
        end
        checks++;
        if (wr_edges.size() != 5 || wr_edges[0] != FIRST || wr_edges[4] != FIRST + 4) begin
            errors++;
            $display("FAIL basic_writes: n=%0d expected 5 from edge %0d",
                     wr_edges.size(), FIRST);
        end
        checks++;
        if (obs_done != 1 || obs_done_edge != FIRST + 5) begin
            errors++;
            $display("FAIL basic_done: n=%0d edge=%0d expected 1/%0d",
                     obs_done, obs_done_edge, FIRST + 5);
        end
        checks++;
        if (count !== 16'd5 || overflow !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_final: count=%0d ovf=%b busy=%b expected 5/0/0",
                     count, overflow, busy);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL basic_missing: %0d writes outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_decim();
        drive_run(3, 2, -1, -1, -1, FIRST + 12);
        checks++;
        if (wr_edges.size() != 3) begin
            errors++;
            $display("FAIL decim_count: got %0d writes expected 3", wr_edges.size());
        end else begin
            checks++;
            if (wr_edges[1] - wr_edges[0] != 3 || wr_edges[2] - wr_edges[1] != 3) begin
                errors++;
                $display("FAIL decim_spacing: got %0d,%0d expected 3,3",
                         wr_edges[1] - wr_edges[0], wr_edges[2] - wr_edges[1]);
            end
        end
        checks++;
        if (obs_done != 1 || obs_done_edge != FIRST + 7) begin
            errors++;
            $display("FAIL decim_done: n=%0d edge=%0d expected 1/%0d",
                     obs_done, obs_done_edge, FIRST + 7);
        end
    endtask

    task automatic test_overflow();
        drive_run(4, 0, 1, -1, -1, FIRST + 8);
        checks++;
        if (wr_edges.size() != 3 || count !== 16'd4) begin
            errors++;
            $display("FAIL ovf_writes: writes=%0d count=%0d expected 3/4",
                     wr_edges.size(), count);
        end
        checks++;
        if (overflow !== 1'b1 || obs_done != 1) begin
            errors++;
            $display("FAIL ovf_flag: ovf=%b done=%0d expected 1/1", overflow, obs_done);
        end
        repeat (3) tick();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b expected 1", overflow);
        end
        drive_run(2, 0, -1, -1, -1, FIRST + 4);
        checks++;
        if (overflow !== 1'b0 || count !== 16'd2 || sb.size() != 0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b count=%0d pending=%0d expected 0/2/0",
                     overflow, count, sb.size());
        end
    endtask

    task automatic test_abort();
        drive_run(10, 0, -1, FIRST + 2, 5, FIRST + 8);
        checks++;
        if (wr_edges.size() != 2 || obs_done != 0) begin
            errors++;
            $display("FAIL abort_writes: writes=%0d done=%0d expected 2/0",
                     wr_edges.size(), obs_done);
        end
        checks++;
        if (obs_busy_abort !== 1'b0 || count !== 16'd2) begin
            errors++;
            $display("FAIL abort_state: busy=%b count=%0d expected 0/2",
                     obs_busy_abort, count);
        end
        checks++;
        if (obs_br != ALIGN) begin
            errors++;
            $display("FAIL abort_midstart: block_reset cycles=%0d expected %0d",
                     obs_br, ALIGN);
        end
        drive_run(1, 0, -1, -1, -1, FIRST + 4);
        checks++;
        if (obs_done != 1 || wr_edges.size() != 1 || sb.size() != 0) begin
            errors++;
            $display("FAIL abort_restart: done=%0d writes=%0d expected 1/1",
                     obs_done, wr_edges.size());
        end
    endtask

    task automatic test_zero_len();
        drive_run(0, 0, -1, -1, -1, 6);
        checks++;
        if (obs_done != 1 || obs_done_edge != 1) begin
            errors++;
            $display("FAIL zero_done: n=%0d edge=%0d expected 1/1", obs_done, obs_done_edge);
        end
        checks++;
        if (obs_br != 0 || wr_edges.size() != 0) begin
            errors++;
            $display("FAIL zero_activity: br=%0d writes=%0d expected 0/0",
                     obs_br, wr_edges.size());
        end
        length = 16'd3;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || block_reset !== 1'b0) begin
            errors++;
            $display("FAIL start_abort: busy=%b br=%b expected 0/0", busy, block_reset);
        end
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_idle: busy=%b done=%b expected 0/0", busy, done);
        end
    endtask

    task automatic test_reset_midrun();
        length = 16'd5;
        decim = '0;
`ifdef CAPTURE_TRIGGER_EN
        trig_level = sample_in + 16'sd13;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        checks++;
        if (block_reset !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_active: br=%b busy=%b expected 1/1", block_reset, busy);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({block_reset, busy, fifo_wr_en, done} !== 4'b0 || count !== '0) begin
            errors++;
            $display("FAIL midrun_reset: flags=%b count=%0d expected 0000/0",
                     {block_reset, busy, fifo_wr_en, done}, count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

`ifdef CAPTURE_TRIGGER_EN
    task automatic test_trigger();
        int sine[16] = '{0, 77, 141, 185, 200, 185, 141, 77,
                         0, -77, -141, -185, -200, -185, -141, -77};
        int c;
        int early;
        logic signed [DATA_W-1:0] v, pv;
        c = -1;
        early = 0;
        trig_level = 16'sd100;
        length = 16'd3;
        decim = '0;
        pv = sample_in;
        for (int e = 0; e < FIRST + 40; e++) begin
            start = (e == 0);
            sample_in = DATA_W'(sine[e % 16]);
            v = sample_in;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (e >= FIRST - 1 && c < 0 && pv < 16'sd100 && 16'sd100 <= v) c = e;
            else if (c >= 0 && e > c && e <= c + 3) sb.push_back(v);
            if (fifo_wr_en && (c < 0 || e <= c)) early++;
            pv = v;
        end
        checks++;
        if (c < 0 || early != 0 || sb.size() != 0) begin
            errors++;
            $display("FAIL trigger: cross=%0d early=%0d pending=%0d expected >=0/0/0",
                     c, early, sb.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_decim();
        test_overflow();
        test_abort();
        test_zero_len();
        test_reset_midrun();
`ifdef CAPTURE_TRIGGER_EN
        test_trigger();
`endif
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
